// File: rtl/fsm_ami_sequencer.sv
// ---------------------------------------------------------------------------
// fsm_ami_sequencer
//
// Accepts one command at a time from the JTAG side, issues it to the AMI
// with a one-cycle request strobe, waits for an acknowledge, and reissues the
// same command on BUSY or on a timeout, up to MAX_RETRY times. The result is
// then offered on a valid/ready response port. A small GPIO block shows the
// FSM state and the last result code on pins, and latches rising edges on
// synchronised external inputs into write-1-to-clear bits that feed an
// interrupt line.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   jtag_in/valid/ready     command payload and handshake (ready = slot free)
//   fsm_ami                 command presented to the AMI
//   ami_req                 one-cycle issue strobe
//   ami_ack                 000 none, 001 OK, 100 BUSY, any other nonzero ERR
//   ami_out                 AMI response payload
//   rsp_data/status         captured response and result code
//                           (00 OK, 01 ERR, 10 BUSY exhausted, 11 timeout)
//   rsp_valid/ready         response handshake
//   gpio_in                 external event inputs
//   gpio_out/gpio_en        {status[1:0], state[2:0]} on bits 4:0, enables
//   gpio_ilat/ilat_clr      latched rising edges, write-1-to-clear
//   gpio_irq                OR of all latched bits
// ---------------------------------------------------------------------------
module fsm_ami_sequencer #(
    parameter int DATA_W    = 256,
    parameter int GPIO_W    = 24,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] jtag_in,
    input  logic              jtag_valid,
    output logic              jtag_ready,
    output logic [DATA_W-1:0] fsm_ami,
    output logic              ami_req,
    input  logic [2:0]        ami_ack,
    input  logic [DATA_W-1:0] ami_out,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_en,
    output logic [GPIO_W-1:0] gpio_ilat,
    input  logic [GPIO_W-1:0] ilat_clr,
    output logic              gpio_irq
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0]  TMR_MAX     = TMR_W'(TIMEOUT);
    localparam logic [RTY_W-1:0]  RTY_MAX     = RTY_W'(MAX_RETRY);
    localparam logic [GPIO_W-1:0] GPIO_EN_VAL = GPIO_W'(5'h1F);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_BUSY = 2'b10;
    localparam logic [1:0] ST_TOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RETRY = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [RTY_W-1:0]  retry_cnt;

    logic ack_ok;
    logic ack_busy;
    logic ack_err;
    logic timed_out;
    logic can_retry;

    // Status pin image: state code on [2:0], result code on [4:3].
    function automatic logic [GPIO_W-1:0] status_pins(input state_t s,
                                                      input logic [1:0] st);
        logic [GPIO_W-1:0] w;
        w      = '0;
        w[2:0] = s;
        w[4:3] = st;
        return w;
    endfunction

    assign ack_ok    = (ami_ack == 3'b001);
    assign ack_busy  = (ami_ack == 3'b100);
    assign ack_err   = (ami_ack != 3'b000) && !ack_ok && !ack_busy;
    assign timed_out = (timer == TMR_MAX);
    assign can_retry = (retry_cnt < RTY_MAX);

    // fsm_ami doubles as the command register: it is loaded on acceptance
    // and simply holds afterwards, so retries reissue the same command and
    // the last command stays visible while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fsm_ami    <= '0;
            timer      <= '0;
            retry_cnt  <= '0;
            jtag_ready <= 1'b1;
            ami_req    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
            gpio_out   <= '0;
        end else begin
            ami_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (jtag_valid) begin
                        fsm_ami    <= jtag_in;
                        retry_cnt  <= '0;
                        jtag_ready <= 1'b0;
                        ami_req    <= 1'b1;
                        state      <= S_ISSUE;
                        gpio_out   <= status_pins(S_ISSUE, rsp_status);
                    end
                end
                S_ISSUE: begin
                    timer    <= '0;
                    state    <= S_WAIT;
                    gpio_out <= status_pins(S_WAIT, rsp_status);
                end
                S_WAIT: begin
                    // Any acknowledge outranks a timeout landing in the same cycle.
                    if (ack_ok) begin
                        rsp_data   <= ami_out;
                        rsp_status <= ST_OK;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                        gpio_out   <= status_pins(S_RESP, ST_OK);
                    end else if (ack_err) begin
                        rsp_status <= ST_ERR;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                        gpio_out   <= status_pins(S_RESP, ST_ERR);
                    end else if (ack_busy || timed_out) begin
                        if (can_retry) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_RETRY;
                            gpio_out  <= status_pins(S_RETRY, rsp_status);
                        end else begin
                            rsp_status <= ack_busy ? ST_BUSY : ST_TOUT;
                            rsp_valid  <= 1'b1;
                            state      <= S_RESP;
                            gpio_out   <= status_pins(S_RESP, ack_busy ? ST_BUSY : ST_TOUT);
                        end
                    end else begin
                        // Leaving WAIT at TMR_MAX keeps the timer from wrapping.
                        timer <= timer + 1'b1;
                    end
                end
                S_RETRY: begin
                    ami_req  <= 1'b1;
                    state    <= S_ISSUE;
                    gpio_out <= status_pins(S_ISSUE, rsp_status);
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        jtag_ready <= 1'b1;
                        state      <= S_IDLE;
                        gpio_out   <= status_pins(S_IDLE, rsp_status);
                    end
                end
                default: begin
                    rsp_valid  <= 1'b0;
                    jtag_ready <= 1'b1;
                    state      <= S_IDLE;
                    gpio_out   <= status_pins(S_IDLE, rsp_status);
                end
            endcase
        end
    end

    logic [GPIO_W-1:0] gpio_sync_p0;
    logic [GPIO_W-1:0] gpio_sync_p1;
    logic [GPIO_W-1:0] gpio_sync_p2;
    logic [GPIO_W-1:0] gpio_rise;

    assign gpio_rise = gpio_sync_p1 & ~gpio_sync_p2;
    assign gpio_irq  = |gpio_ilat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_sync_p0 <= '0;
            gpio_sync_p1 <= '0;
            gpio_sync_p2 <= '0;
            gpio_ilat    <= '0;
            gpio_en      <= GPIO_EN_VAL;
        end else begin
            // p0 -> p1: two-flop synchroniser for the asynchronous inputs
            gpio_sync_p0 <= gpio_in;
            gpio_sync_p1 <= gpio_sync_p0;
            // p1 -> p2: previous synchronised value for edge detection
            gpio_sync_p2 <= gpio_sync_p1;
            // Clear first, then OR in new edges, so a coincident edge wins.
            gpio_ilat    <= (gpio_ilat & ~ilat_clr) | gpio_rise;
            gpio_en      <= GPIO_EN_VAL;
        end
    end

endmodule

// File: doc/fsm_ami_sequencer.md
FSM_AMI_SEQUENCER -- requirements
Module: fsm_ami_sequencer

Interface
REQ-001 Parameter DATA_W, default 256, command/response payload width.
REQ-002 Parameter GPIO_W, default 24, GPIO width; SHALL be >= 8.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before timeout; range 1..65535.
REQ-004 Parameter MAX_RETRY, default 2, number of reissues allowed after BUSY or timeout.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 jtag_in  in  DATA_W  command payload.
REQ-008 jtag_valid  in  1  command offered.
REQ-009 jtag_ready  out  1  command slot free.
REQ-010 fsm_ami  out  DATA_W  command presented to AMI.
REQ-011 ami_req  out  1  one-cycle issue strobe to AMI.
REQ-012 ami_ack  in  3  AMI ack code: 000 none, 001 OK, 010 ERR, 100 BUSY; all other nonzero codes are treated as ERR.
REQ-013 ami_out  in  DATA_W  AMI response payload.
REQ-014 rsp_data  out  DATA_W  captured response.
REQ-015 rsp_status  out  2  result code: 00 OK, 01 ERR, 10 BUSY-exhausted, 11 timeout.
REQ-016 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-017 gpio_in  in  GPIO_W  external event inputs.
REQ-018 gpio_out / gpio_en  out  GPIO_W  status pins and their output enables.
REQ-019 gpio_ilat  out  GPIO_W  latched rising-edge events.
REQ-020 ilat_clr  in  GPIO_W  write-1-to-clear for gpio_ilat.
REQ-021 gpio_irq  out  1  OR of all gpio_ilat bits.

Function
REQ-022 The FSM SHALL use states IDLE=0, ISSUE=1, WAIT=2, RETRY=3, RESP=4.
REQ-023 IDLE: jtag_ready=1; when jtag_valid=1, latch jtag_in into cmd, clear retry_cnt, and go to ISSUE.
REQ-024 ISSUE: ami_req=1 for exactly this cycle; clear timer; go to WAIT.
REQ-025 fsm_ami SHALL equal cmd from ISSUE through the end of RESP, and hold its last value in IDLE.
REQ-026 ami_ack SHALL be sampled only in WAIT and ignored in all other states.
REQ-027 WAIT transitions:
- ack OK: rsp_data <= ami_out, status 00, go to RESP.
- ack ERR: status 01, go to RESP; rsp_data unchanged.
- ack BUSY, or timer == TIMEOUT with no ack: if retry_cnt < MAX_RETRY, increment retry_cnt and go to RETRY; otherwise status 10 (BUSY) or 11 (timeout) and go to RESP.
- otherwise: timer increments.
REQ-028 A nonzero ack in the cycle where timer == TIMEOUT SHALL take priority over the timeout.
REQ-029 The timer SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.
REQ-030 RETRY SHALL last one cycle, then go to ISSUE; the retry reissues the same cmd.
REQ-031 RESP: rsp_valid=1, with rsp_data and rsp_status stable; on rsp_ready=1 go to IDLE.
REQ-032 jtag_valid outside IDLE SHALL be ignored; a command is accepted only when jtag_ready=1.
REQ-033 Latency: jtag_valid accepted at cycle 0 -> ami_req at cycle 1 -> ack OK at cycle k (k>=2) -> rsp_valid at cycle k+1.
REQ-034 gpio_out[2:0] SHALL carry the state code, gpio_out[4:3] the last rsp_status, and all other bits SHALL be 0; gpio_en[4:0]=1 and all other bits 0; both registered.
REQ-035 gpio_in SHALL pass through a 2-flop synchroniser; a rising edge on the synchronised bit i sets gpio_ilat[i].
REQ-036 ilat_clr[i]=1 SHALL clear gpio_ilat[i]; if set and clear occur in the same cycle, set wins.
REQ-037 gpio_irq SHALL be the combinational OR of gpio_ilat.

Reset
REQ-038 When rst_n=0, all outputs and internal registers SHALL be 0 and the state IDLE, except jtag_ready and gpio_en, which take their IDLE/constant values (1 and 0x1F).
REQ-039 Reset asserted mid-transaction SHALL abort it with no rsp_valid; after release, the FSM accepts a new command in IDLE.
REQ-040 The synchroniser SHALL reset to 0, so a gpio_in held high through reset produces one latch event 2-3 cycles after release.

Verification
REQ-041 Nominal: jtag_in=0xA5, ack OK with ami_out=0x5A three cycles after ami_req -> rsp_data=0x5A, rsp_status=00, gpio_out[4:0]=0x04 during RESP.
REQ-042 Retry: TIMEOUT=8, MAX_RETRY=2; ack BUSY, BUSY, then OK -> three ami_req pulses with identical fsm_ami, then status 00.
REQ-043 Timeout: TIMEOUT=8, MAX_RETRY=2; no ack -> three issues, each WAIT lasting 9 cycles, then status 11; ack OK on timer==8 -> status 00 with no retry.
REQ-044 Backpressure/ERR: ack=011 -> status 01; rsp_ready held low for 10 cycles -> rsp_valid stays high and data stable; jtag_valid pulses in that window are ignored.
REQ-045 GPIO: rising edge on gpio_in[7] -> gpio_ilat[7]=1 and gpio_irq=1 three cycles later; ilat_clr[7] coincident with a new edge -> bit stays set.
REQ-046 Reset mid-WAIT: rst_n low for 1 cycle -> all outputs at reset values, no rsp_valid; the next command completes normally.
